traffic_phase_sequencer: RTL and testbench

Parametrised successor to the single-intersection light controller. Sequences GREEN → YELLOW → ALL-RED phases over `NUM_LANES` approach lanes and adapts green time to per-lane queue counts. Adds day/night timing, a latched pedestrian phase and emergency pre-emption of any lane. Sits between the lane-count sensors and the light/walk drivers on the Breadboard.

---
 rtl/traffic_phase_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
//
// Multi-lane traffic light sequencer. Cycles GREEN -> YELLOW -> ALL-RED
// over NUM_LANES approach lanes. Green time adapts to the queue count of
// the lane being served (day mode) or is fixed (night mode). Supports a
// latched pedestrian phase and emergency pre-emption of any lane.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   hoursIn             current hour; day/night is decided at GREEN entry
//   pedSignal           pedestrian request; a one-cycle pulse is latched
//   emgSignal           emergency active (level)
//   emgLane             one-hot emergency lane; lowest set bit wins, zero ignored
//   laneCounts          per-lane queue counts, lane i at [i*CNT_W +: CNT_W]
//   trafficLightOutput  green per lane (at most one set)
//   yellowOutput        yellow per lane (at most one set)
//   walkingLightOutput  walk per crossing (all set during the pedestrian phase)
//   trafficMode         00 day, 01 night, 10 pedestrian, 11 emergency
//   currentCount        remaining cycles in the current state, minus one
//   isZero              high when currentCount is zero

module traffic_phase_sequencer #(
  parameter int NUM_LANES   = 8,
  parameter int CNT_W       = 8,
  parameter int HOURS_W     = 5,
  parameter int GREEN_DAY   = 10,
  parameter int GREEN_NIGHT = 4,
  parameter int EXT_MAX     = 6,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 1,
  parameter int PED_T       = 6,
  parameter int EMG_T       = 8,
  parameter int DAY_START   = 6,
  parameter int DAY_END     = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [HOURS_W-1:0]           hoursIn,
  input  logic                         pedSignal,
  input  logic                         emgSignal,
  input  logic [NUM_LANES-1:0]         emgLane,
  input  logic [NUM_LANES*CNT_W-1:0]   laneCounts,
  output logic [NUM_LANES-1:0]         trafficLightOutput,
  output logic [NUM_LANES-1:0]         yellowOutput,
  output logic [NUM_LANES-1:0]         walkingLightOutput,
  output logic [1:0]                   trafficMode,
  output logic [CNT_W-1:0]             currentCount,
  output logic                         isZero
);

  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic [2:0] {
    S_ALLRED,
    S_GREEN,
    S_YELLOW,
    S_PED,
    S_EMG
  } state_t;

  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] PED_LOAD    = CNT_W'(PED_T - 1);
  localparam logic [CNT_W-1:0] EMG_LOAD    = CNT_W'(EMG_T - 1);

  state_t               state_q, state_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ped_pending_q, ped_pending_d;
  logic                 night_q, night_d;
  logic [NUM_LANES-1:0] green_q, green_d;
  logic [NUM_LANES-1:0] yellow_q, yellow_d;
  logic [NUM_LANES-1:0] walk_q, walk_d;
  logic [1:0]           mode_q, mode_d;

  logic                 is_zero;
  logic                 is_day;
  logic                 emg_pending;
  logic [LANE_W-1:0]    emg_target;
  logic [LANE_W-1:0]    next_lane;
  logic [LANE_W-1:0]    cand_lane;
  logic [CNT_W-1:0]     sel_count;
  logic [CNT_W-1:0]     ext;
  logic [CNT_W-1:0]     green_load;
  logic                 ped_enter;

  assign is_zero     = (count_q == '0);
  assign is_day      = (int'(hoursIn) >= DAY_START) && (int'(hoursIn) < DAY_END);
  assign emg_pending = emgSignal && (|emgLane);

  // Lowest set bit of emgLane names the emergency lane. Scanning from the
  // top down lets the lowest match overwrite any higher one.
  always_comb begin
    emg_target = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (emgLane[i]) begin
        emg_target = LANE_W'(i);
      end
    end
  end

  // Circular search for the next lane with waiting traffic, starting one
  // past the lane last served. Scanning offsets from far to near means the
  // nearest nonzero lane is the last assignment. Offset NUM_LANES wraps to
  // the current lane itself, so a lone busy lane keeps being served. With
  // no traffic anywhere the default simply advances by one lane.
  always_comb begin
    next_lane = lane_q + LANE_W'(1);
    cand_lane = '0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      cand_lane = lane_q + LANE_W'(i);
      if (laneCounts[int'(cand_lane)*CNT_W +: CNT_W] != '0) begin
        next_lane = cand_lane;
      end
    end
  end

  // Green length for the lane about to be served. Day mode adds a quarter
  // of the queue count, capped at EXT_MAX; night mode is a fixed length.
  // The value produced is the countdown load, i.e. length minus one.
  always_comb begin
    sel_count = laneCounts[int'(next_lane)*CNT_W +: CNT_W];
    ext       = sel_count >> 2;
    if (ext > CNT_W'(EXT_MAX)) begin
      ext = CNT_W'(EXT_MAX);
    end
    if (is_day) begin
      green_load = CNT_W'(GREEN_DAY) + ext - CNT_W'(1);
    end else begin
      green_load = CNT_W'(GREEN_NIGHT - 1);
    end
  end

  // Next-state logic. The countdown decrements by default and stops at
  // zero; each state leaves on the cycle its count is zero, loading the
  // length of the state it enters. EMG is the only state that can sit at
  // zero, for as long as the emergency is still signalled.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    night_d   = night_q;
    ped_enter = 1'b0;
    if (is_zero) begin
      count_d = count_q;
    end else begin
      count_d = count_q - CNT_W'(1);
    end

    case (state_q)
      S_ALLRED: begin
        if (is_zero) begin
          if (emg_pending) begin
            state_d = S_EMG;
            lane_d  = emg_target;
            count_d = EMG_LOAD;
          end else if (ped_pending_q) begin
            state_d   = S_PED;
            count_d   = PED_LOAD;
            ped_enter = 1'b1;
          end else begin
            state_d = S_GREEN;
            lane_d  = next_lane;
            count_d = green_load;
            night_d = !is_day;
          end
        end
      end

      // An emergency for the lane already green converts straight into
      // EMG without a yellow; any other emergency cuts the green short.
      S_GREEN: begin
        if (emg_pending && (lane_q == emg_target)) begin
          state_d = S_EMG;
          count_d = EMG_LOAD;
        end else if (emg_pending || is_zero) begin
          state_d = S_YELLOW;
          count_d = YELLOW_LOAD;
        end
      end

      S_YELLOW: begin
        if (is_zero) begin
          state_d = S_ALLRED;
          count_d = ALLRED_LOAD;
        end
      end

      S_PED: begin
        if (emg_pending || is_zero) begin
          state_d = S_ALLRED;
          count_d = ALLRED_LOAD;
        end
      end

      // The emergency green lasts at least EMG_T cycles; once the minimum
      // has run out it is held until emgSignal drops. lane_q keeps the
      // emergency lane so normal selection resumes from the lane after it.
      S_EMG: begin
        if (is_zero && !emgSignal) begin
          state_d = S_YELLOW;
          count_d = YELLOW_LOAD;
        end
      end

      default: begin
        state_d = S_ALLRED;
        count_d = '0;
      end
    endcase
  end

  // Pedestrian request latch: a new request in the same cycle as PED entry
  // survives, so it is served on a later pedestrian phase.
  always_comb begin
    ped_pending_d = pedSignal | (ped_pending_q & ~ped_enter);
  end

  // Output decode from the next-state values, so the lights change on the
  // same edge as the state and come straight from flops.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    walk_d   = '0;
    mode_d   = {1'b0, night_d};
    case (state_d)
      S_GREEN: begin
        green_d[lane_d] = 1'b1;
      end
      S_YELLOW: begin
        yellow_d[lane_d] = 1'b1;
      end
      S_PED: begin
        walk_d = '1;
        mode_d = 2'b10;
      end
      S_EMG: begin
        green_d[lane_d] = 1'b1;
        mode_d          = 2'b11;
      end
      default: begin
        green_d = '0;
      end
    endcase
  end

  // State and output registers. Reset parks the controller in ALL-RED with
  // an expired count and the last lane selected, so the first green goes
  // to the first busy lane starting from lane 0 one cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ALLRED;
      lane_q        <= LANE_W'(NUM_LANES - 1);
      count_q       <= '0;
      ped_pending_q <= 1'b0;
      night_q       <= 1'b0;
      green_q       <= '0;
      yellow_q      <= '0;
      walk_q        <= '0;
      mode_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      count_q       <= count_d;
      ped_pending_q <= ped_pending_d;
      night_q       <= night_d;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      walk_q        <= walk_d;
      mode_q        <= mode_d;
    end
  end

  assign trafficLightOutput = green_q;
  assign yellowOutput       = yellow_q;
  assign walkingLightOutput = walk_q;
  assign trafficMode        = mode_q;
  assign currentCount       = count_q;
  assign isZero             = is_zero;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer
//
// Directed bench for traffic_phase_sequencer with default parameters
// (8 lanes, 8-bit counts). A table of {inputs, cycles, expected outputs}
// records covers reset, start-up, empty-lane skipping, night timing and
// extension saturation; hand-written sequences cover the pedestrian phase,
// emergency pre-emption and reset during an emergency.

module tb_traffic_phase_sequencer;

  logic        clk;
  logic        rst;
  logic [4:0]  hoursIn;
  logic        pedSignal;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [63:0] laneCounts;
  logic [7:0]  trafficLightOutput;
  logic [7:0]  yellowOutput;
  logic [7:0]  walkingLightOutput;
  logic [1:0]  trafficMode;
  logic [7:0]  currentCount;
  logic        isZero;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic [4:0]  hours;
    logic [63:0] counts;
    int          ncyc;
    logic [7:0]  expGreen;
    logic [7:0]  expYellow;
    logic [1:0]  expMode;
    logic [7:0]  expCount;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] CNT_NONE  = 64'h0;
  localparam logic [63:0] CNT_LANE5 = 64'h0000_0800_0000_0000;
  localparam logic [63:0] CNT_SAT   = {8{8'hC8}};

  traffic_phase_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .hoursIn            (hoursIn),
    .pedSignal          (pedSignal),
    .emgSignal          (emgSignal),
    .emgLane            (emgLane),
    .laneCounts         (laneCounts),
    .trafficLightOutput (trafficLightOutput),
    .yellowOutput       (yellowOutput),
    .walkingLightOutput (walkingLightOutput),
    .trafficMode        (trafficMode),
    .currentCount       (currentCount),
    .isZero             (isZero)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic applyStimulus(input logic r, input logic [4:0] h, input logic p,
                               input logic e, input logic [7:0] el, input logic [63:0] c);
    @(negedge clk);
    rst        = r;
    hoursIn    = h;
    pedSignal  = p;
    emgSignal  = e;
    emgLane    = el;
    laneCounts = c;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s %s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eg, input logic [7:0] ey,
                             input logic [7:0] ew, input logic [1:0] em, input logic [7:0] ec);
    cmp(name, "green",  32'(trafficLightOutput), 32'(eg));
    cmp(name, "yellow", 32'(yellowOutput),       32'(ey));
    cmp(name, "walk",   32'(walkingLightOutput), 32'(ew));
    cmp(name, "mode",   32'(trafficMode),        32'(em));
    cmp(name, "count",  32'(currentCount),       32'(ec));
    cmp(name, "isZero", 32'(isZero),             32'(ec == 8'd0));
  endtask

  task automatic addVec(input logic r, input logic [4:0] h, input logic [63:0] c, input int n,
                        input logic [7:0] eg, input logic [7:0] ey, input logic [1:0] em,
                        input logic [7:0] ec);
    vec_t v;
    v.rst       = r;
    v.hours     = h;
    v.counts    = c;
    v.ncyc      = n;
    v.expGreen  = eg;
    v.expYellow = ey;
    v.expMode   = em;
    v.expCount  = ec;
    vecs.push_back(v);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    hoursIn    = 5'd12;
    pedSignal  = 1'b0;
    emgSignal  = 1'b0;
    emgLane    = 8'h00;
    laneCounts = CNT_NONE;

    // Start-up with no traffic: lane 0 first, 10-cycle greens, lanes advance.
    addVec(1, 12, CNT_NONE, 2, 8'h00, 8'h00, 2'b00, 0);
    addVec(0, 12, CNT_NONE, 1, 8'h01, 8'h00, 2'b00, 9);
    addVec(0, 12, CNT_NONE, 9, 8'h01, 8'h00, 2'b00, 0);
    addVec(0, 12, CNT_NONE, 1, 8'h00, 8'h01, 2'b00, 2);
    addVec(0, 12, CNT_NONE, 3, 8'h00, 8'h00, 2'b00, 0);
    addVec(0, 12, CNT_NONE, 1, 8'h02, 8'h00, 2'b00, 9);
    // Only lane 5 busy (count 8 -> extension 2): lane 5 served repeatedly.
    addVec(1, 12, CNT_LANE5, 2, 8'h00, 8'h00, 2'b00, 0);
    addVec(0, 12, CNT_LANE5, 1, 8'h20, 8'h00, 2'b00, 11);
    addVec(0, 12, CNT_LANE5, 11, 8'h20, 8'h00, 2'b00, 0);
    addVec(0, 12, CNT_LANE5, 1, 8'h00, 8'h20, 2'b00, 2);
    addVec(0, 12, CNT_LANE5, 3, 8'h00, 8'h00, 2'b00, 0);
    addVec(0, 12, CNT_LANE5, 1, 8'h20, 8'h00, 2'b00, 11);
    // Night with saturated counts: fixed 4-cycle greens, mode 01.
    addVec(1, 22, CNT_SAT, 1, 8'h00, 8'h00, 2'b00, 0);
    addVec(0, 22, CNT_SAT, 1, 8'h01, 8'h00, 2'b01, 3);
    addVec(0, 22, CNT_SAT, 3, 8'h01, 8'h00, 2'b01, 0);
    addVec(0, 22, CNT_SAT, 1, 8'h00, 8'h01, 2'b01, 2);
    addVec(0, 22, CNT_SAT, 3, 8'h00, 8'h00, 2'b01, 0);
    addVec(0, 22, CNT_SAT, 1, 8'h02, 8'h00, 2'b01, 3);
    // Switch to day mid-green: mode only follows at the next GREEN entry.
    addVec(0, 12, CNT_SAT, 4, 8'h00, 8'h02, 2'b01, 2);
    addVec(0, 12, CNT_SAT, 3, 8'h00, 8'h00, 2'b01, 0);
    // Day with saturated counts: 10 + min(50, 6) = 16 cycles.
    addVec(0, 12, CNT_SAT, 1, 8'h04, 8'h00, 2'b00, 15);
    addVec(0, 12, CNT_SAT, 15, 8'h04, 8'h00, 2'b00, 0);
    addVec(0, 12, CNT_SAT, 1, 8'h00, 8'h04, 2'b00, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].hours, 1'b0, 1'b0, 8'h00, vecs[i].counts);
      tick(vecs[i].ncyc);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGreen, vecs[i].expYellow, 8'h00,
                  vecs[i].expMode, vecs[i].expCount);
    end

    // Pedestrian pulse during lane-1 green, served after the next ALL-RED.
    applyStimulus(1, 12, 0, 0, 8'h00, CNT_NONE);
    tick(2);
    checkOutput("ped_reset", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    applyStimulus(0, 12, 0, 0, 8'h00, CNT_NONE);
    tick(1);
    checkOutput("ped_g0", 8'h01, 8'h00, 8'h00, 2'b00, 9);
    tick(14);
    checkOutput("ped_g1", 8'h02, 8'h00, 8'h00, 2'b00, 9);
    applyStimulus(0, 12, 1, 0, 8'h00, CNT_NONE);
    tick(1);
    checkOutput("ped_req", 8'h02, 8'h00, 8'h00, 2'b00, 8);
    applyStimulus(0, 12, 0, 0, 8'h00, CNT_NONE);
    tick(8);
    checkOutput("ped_g1_end", 8'h02, 8'h00, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("ped_y1", 8'h00, 8'h02, 8'h00, 2'b00, 2);
    tick(3);
    checkOutput("ped_allred", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("ped_walk", 8'h00, 8'h00, 8'hFF, 2'b10, 5);
    tick(5);
    checkOutput("ped_walk_end", 8'h00, 8'h00, 8'hFF, 2'b10, 0);
    tick(1);
    checkOutput("ped_allred2", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("ped_g2", 8'h04, 8'h00, 8'h00, 2'b00, 9);
    tick(14);
    checkOutput("ped_no_repeat", 8'h08, 8'h00, 8'h00, 2'b00, 9);

    // Emergency on lane 3 raised during lane-1 green.
    applyStimulus(1, 12, 0, 0, 8'h00, CNT_NONE);
    tick(2);
    checkOutput("emg_reset", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    applyStimulus(0, 12, 0, 0, 8'h00, CNT_NONE);
    tick(1);
    checkOutput("emg_g0", 8'h01, 8'h00, 8'h00, 2'b00, 9);
    applyStimulus(0, 12, 0, 1, 8'h00, CNT_NONE);
    tick(1);
    checkOutput("emg_nolane", 8'h01, 8'h00, 8'h00, 2'b00, 8);
    applyStimulus(0, 12, 0, 0, 8'h00, CNT_NONE);
    tick(13);
    checkOutput("emg_g1", 8'h02, 8'h00, 8'h00, 2'b00, 9);
    applyStimulus(0, 12, 0, 1, 8'h08, CNT_NONE);
    tick(1);
    checkOutput("emg_y1", 8'h00, 8'h02, 8'h00, 2'b00, 2);
    tick(2);
    checkOutput("emg_y1_end", 8'h00, 8'h02, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("emg_allred", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("emg_enter", 8'h08, 8'h00, 8'h00, 2'b11, 7);
    tick(7);
    checkOutput("emg_min", 8'h08, 8'h00, 8'h00, 2'b11, 0);
    tick(8);
    checkOutput("emg_hold", 8'h08, 8'h00, 8'h00, 2'b11, 0);
    applyStimulus(0, 12, 0, 0, 8'h08, CNT_NONE);
    tick(1);
    checkOutput("emg_exit", 8'h00, 8'h08, 8'h00, 2'b00, 2);
    tick(3);
    checkOutput("emg_allred2", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("emg_resume", 8'h10, 8'h00, 8'h00, 2'b00, 9);

    // Emergency for the lane already green (lanes 4 and 6, lowest wins):
    // straight to EMG, which still runs its full minimum length.
    applyStimulus(0, 12, 0, 1, 8'h50, CNT_NONE);
    tick(1);
    checkOutput("emg_same", 8'h10, 8'h00, 8'h00, 2'b11, 7);
    applyStimulus(0, 12, 0, 0, 8'h00, CNT_NONE);
    tick(7);
    checkOutput("emg_same_min", 8'h10, 8'h00, 8'h00, 2'b11, 0);
    tick(1);
    checkOutput("emg_same_exit", 8'h00, 8'h10, 8'h00, 2'b00, 2);

    // Reset while in EMG on lane 2 aborts at the next edge.
    applyStimulus(0, 12, 0, 1, 8'h04, CNT_NONE);
    tick(2);
    checkOutput("rst_emg_y", 8'h00, 8'h10, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("rst_emg_allred", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tick(1);
    checkOutput("rst_emg_enter", 8'h04, 8'h00, 8'h00, 2'b11, 7);
    applyStimulus(1, 12, 0, 1, 8'h04, CNT_NONE);
    tick(1);
    checkOutput("rst_emg_abort", 8'h00, 8'h00, 8'h00, 2'b00, 0);
    applyStimulus(0, 12, 0, 0, 8'h00, CNT_NONE);
    tick(1);
    checkOutput("rst_emg_restart", 8'h01, 8'h00, 8'h00, 2'b00, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
